// File: rtl/sniffer_cfg_pkg.sv
// Shared constants, register map and FSM state type for the sniffer configuration controller.
package sniffer_cfg_pkg;

    localparam int unsigned STR_BYTES  = 17;
    localparam int unsigned STRLEN_MAX = 17;
    localparam int unsigned STRLEN_W   = 5;
    localparam int unsigned HIT_W      = 64;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned CFG_W      = 32;
    localparam int unsigned STR_W      = 8 * STR_BYTES;

    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5'h00);
    localparam logic [ADDR_W-1:0] A_PORT    = ADDR_W'(5'h01);
    localparam logic [ADDR_W-1:0] A_IP      = ADDR_W'(5'h02);
    localparam logic [ADDR_W-1:0] A_MAC_LO  = ADDR_W'(5'h03);
    localparam logic [ADDR_W-1:0] A_MAC_HI  = ADDR_W'(5'h04);
    localparam logic [ADDR_W-1:0] A_STRLEN  = ADDR_W'(5'h05);
    localparam logic [ADDR_W-1:0] A_STR0    = ADDR_W'(5'h08);
    localparam logic [ADDR_W-1:0] A_STR1    = ADDR_W'(5'h09);
    localparam logic [ADDR_W-1:0] A_STR2    = ADDR_W'(5'h0A);
    localparam logic [ADDR_W-1:0] A_STR3    = ADDR_W'(5'h0B);
    localparam logic [ADDR_W-1:0] A_STR4    = ADDR_W'(5'h0C);
    localparam logic [ADDR_W-1:0] A_PH_LO   = ADDR_W'(5'h10);
    localparam logic [ADDR_W-1:0] A_PH_HI   = ADDR_W'(5'h11);
    localparam logic [ADDR_W-1:0] A_IH_LO   = ADDR_W'(5'h12);
    localparam logic [ADDR_W-1:0] A_IH_HI   = ADDR_W'(5'h13);
    localparam logic [ADDR_W-1:0] A_MH_LO   = ADDR_W'(5'h14);
    localparam logic [ADDR_W-1:0] A_MH_HI   = ADDR_W'(5'h15);
    localparam logic [ADDR_W-1:0] A_UH_LO   = ADDR_W'(5'h16);
    localparam logic [ADDR_W-1:0] A_UH_HI   = ADDR_W'(5'h17);

    // CTRL write bits
    localparam int unsigned CTRL_COMMIT   = 0;
    localparam int unsigned CTRL_CLR_HITS = 1;
    localparam int unsigned CTRL_CLR_OVR  = 2;
    // CTRL read bits
    localparam int unsigned CTRL_BUSY     = 0;
    localparam int unsigned CTRL_IN_PKT   = 1;
    localparam int unsigned CTRL_OVERRUN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GAP = 2'd1,
        ST_APPLY    = 2'd2
    } state_t;

endpackage

// File: rtl/sniffer_cfg_ctrl_pkt_boundary_tracker.sv
// Tracks whether the sniffer input stream is between sop and eop.
module pkt_boundary_tracker (
    input  logic clk,
    input  logic rst,
    input  logic sop,
    input  logic eop,
    input  logic valid,
    input  logic ready,
    output logic in_packet,
    output logic in_packet_next
);

    logic w_beat;

    assign w_beat = valid & ready;

    // eop wins so a single-beat packet never opens a packet
    always_comb begin
        in_packet_next = in_packet;
        if (w_beat && eop) begin
            in_packet_next = 1'b0;
        end else if (w_beat && sop) begin
            in_packet_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_packet <= 1'b0;
        end else begin
            in_packet <= in_packet_next;
        end
    end

endmodule

// File: rtl/sniffer_cfg_ctrl.sv
// Host register bank with shadow/active match targets committed at packet boundaries,
// plus atomic lo/hi readout of the sniffer's 64-bit hit counters.
module sniffer_cfg_ctrl
    import sniffer_cfg_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              cfg_addr,
    input  logic                           cfg_write,
    input  logic [CFG_W-1:0]               cfg_wdata,
    input  logic                           cfg_read,
    output logic [CFG_W-1:0]               cfg_rdata,
    output logic                           cfg_rvalid,
    input  logic                           sop,
    input  logic                           eop,
    input  logic                           valid,
    input  logic                           ready,
    input  logic [HIT_W-1:0]               port_hits,
    input  logic [HIT_W-1:0]               ip_hits,
    input  logic [HIT_W-1:0]               mac_hits,
    input  logic [HIT_W-1:0]               url_hits,
    output logic [15:0]                    flagged_port,
    output logic [31:0]                    flagged_ip,
    output logic [47:0]                    flagged_mac,
    output logic [0:STR_BYTES-1][7:0]      flagged_string,
    output logic [STRLEN_W-1:0]            strlen,
    output logic                           update_done,
    output logic                           clear,
    output logic                           busy
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_apply;
    logic                  w_in_packet;
    logic                  w_in_packet_next;
    logic                  w_beat;
    logic                  w_ctrl_wr;
    logic                  w_commit_wr;
    logic                  r_clr_req;
    logic                  r_overrun;

    logic [15:0]           r_port_sh;
    logic [31:0]           r_ip_sh;
    logic [47:0]           r_mac_sh;
    logic [STR_W-1:0]      r_str_sh;
    logic [STRLEN_W-1:0]   r_strlen_sh;

    logic [31:0]           r_hit_hold;
    logic                  w_hold_load;
    logic [31:0]           w_hold_val;
    logic [CFG_W-1:0]      w_rdata;

    pkt_boundary_tracker u_tracker (
        .clk            (clk),
        .rst            (rst),
        .sop            (sop),
        .eop            (eop),
        .valid          (valid),
        .ready          (ready),
        .in_packet      (w_in_packet),
        .in_packet_next (w_in_packet_next)
    );

    assign w_beat      = valid & ready;
    assign w_ctrl_wr   = cfg_write && (cfg_addr == A_CTRL);
    // a clear_hits-only request is treated as a commit
    assign w_commit_wr = w_ctrl_wr && (cfg_wdata[CTRL_COMMIT] || cfg_wdata[CTRL_CLR_HITS]);

    always_comb begin
        w_state_next = r_state;
        w_apply      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_commit_wr) begin
                    w_state_next = w_in_packet_next ? ST_WAIT_GAP : ST_APPLY;
                end
            end
            ST_WAIT_GAP: begin
                if (w_beat && eop) begin
                    w_state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_apply      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata     = '0;
        w_hold_load = 1'b0;
        w_hold_val  = '0;
        case (cfg_addr)
            A_CTRL: begin
                w_rdata[CTRL_BUSY]    = busy;
                w_rdata[CTRL_IN_PKT]  = w_in_packet;
                w_rdata[CTRL_OVERRUN] = r_overrun;
            end
            A_PORT:   w_rdata = {16'h0, r_port_sh};
            A_IP:     w_rdata = r_ip_sh;
            A_MAC_LO: w_rdata = r_mac_sh[31:0];
            A_MAC_HI: w_rdata = {16'h0, r_mac_sh[47:32]};
            A_STRLEN: w_rdata = {27'h0, r_strlen_sh};
            A_STR0:   w_rdata = r_str_sh[STR_W-1  -: 32];
            A_STR1:   w_rdata = r_str_sh[STR_W-33 -: 32];
            A_STR2:   w_rdata = r_str_sh[STR_W-65 -: 32];
            A_STR3:   w_rdata = r_str_sh[STR_W-97 -: 32];
            A_STR4:   w_rdata = {r_str_sh[7:0], 24'h0};
            A_PH_LO: begin
                w_rdata     = port_hits[31:0];
                w_hold_load = 1'b1;
                w_hold_val  = port_hits[63:32];
            end
            A_IH_LO: begin
                w_rdata     = ip_hits[31:0];
                w_hold_load = 1'b1;
                w_hold_val  = ip_hits[63:32];
            end
            A_MH_LO: begin
                w_rdata     = mac_hits[31:0];
                w_hold_load = 1'b1;
                w_hold_val  = mac_hits[63:32];
            end
            A_UH_LO: begin
                w_rdata     = url_hits[31:0];
                w_hold_load = 1'b1;
                w_hold_val  = url_hits[63:32];
            end
            A_PH_HI, A_IH_HI, A_MH_HI, A_UH_HI: w_rdata = r_hit_hold;
            default:  w_rdata = '0;
        endcase
    end

    // state, commit and status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_clr_req      <= 1'b0;
            r_overrun      <= 1'b0;
            busy           <= 1'b0;
            update_done    <= 1'b0;
            clear          <= 1'b0;
            flagged_port   <= '0;
            flagged_ip     <= '0;
            flagged_mac    <= '0;
            flagged_string <= '0;
            strlen         <= '0;
        end else begin
            r_state     <= w_state_next;
            busy        <= (w_state_next != ST_IDLE);
            update_done <= w_apply;
            clear       <= w_apply && r_clr_req;
            if ((r_state == ST_IDLE) && w_commit_wr) begin
                r_clr_req <= cfg_wdata[CTRL_CLR_HITS];
            end
            if (w_ctrl_wr && cfg_wdata[CTRL_CLR_OVR]) begin
                r_overrun <= 1'b0;
            end
            if ((r_state != ST_IDLE) && w_commit_wr) begin
                r_overrun <= 1'b1;
            end
            if (w_apply) begin
                r_clr_req      <= 1'b0;
                flagged_port   <= r_port_sh;
                flagged_ip     <= r_ip_sh;
                flagged_mac    <= r_mac_sh;
                flagged_string <= r_str_sh;
                strlen         <= r_strlen_sh;
            end
        end
    end

    // shadow registers, accepted regardless of commit state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_sh   <= '0;
            r_ip_sh     <= '0;
            r_mac_sh    <= '0;
            r_str_sh    <= '0;
            r_strlen_sh <= '0;
        end else if (cfg_write) begin
            case (cfg_addr)
                A_PORT:   r_port_sh <= cfg_wdata[15:0];
                A_IP:     r_ip_sh <= cfg_wdata;
                A_MAC_LO: r_mac_sh[31:0] <= cfg_wdata;
                A_MAC_HI: r_mac_sh[47:32] <= cfg_wdata[15:0];
                A_STRLEN: begin
                    if (cfg_wdata > CFG_W'(STRLEN_MAX)) begin
                        r_strlen_sh <= STRLEN_W'(STRLEN_MAX);
                    end else begin
                        r_strlen_sh <= cfg_wdata[STRLEN_W-1:0];
                    end
                end
                A_STR0:   r_str_sh[STR_W-1  -: 32] <= cfg_wdata;
                A_STR1:   r_str_sh[STR_W-33 -: 32] <= cfg_wdata;
                A_STR2:   r_str_sh[STR_W-65 -: 32] <= cfg_wdata;
                A_STR3:   r_str_sh[STR_W-97 -: 32] <= cfg_wdata;
                A_STR4:   r_str_sh[7:0] <= cfg_wdata[31:24];
                default:  ;
            endcase
        end
    end

    // read port; the mux sees pre-write shadow values
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata  <= '0;
            cfg_rvalid <= 1'b0;
            r_hit_hold <= '0;
        end else begin
            cfg_rvalid <= cfg_read;
            if (cfg_read) begin
                cfg_rdata <= w_rdata;
                if (w_hold_load) begin
                    r_hit_hold <= w_hold_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_sniffer_cfg_ctrl.sv
// Scoreboard bench: stimulus pushes expected reads/commits, a negedge monitor pops and compares.
module tb_sniffer_cfg_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   cfg_addr;
    logic         cfg_write;
    logic [31:0]  cfg_wdata;
    logic         cfg_read;
    logic [31:0]  cfg_rdata;
    logic         cfg_rvalid;
    logic         sop, eop, valid, ready;
    logic [63:0]  port_hits, ip_hits, mac_hits, url_hits;
    logic [15:0]  flagged_port;
    logic [31:0]  flagged_ip;
    logic [47:0]  flagged_mac;
    logic [0:16][7:0] flagged_string;
    logic [4:0]   strlen;
    logic         update_done, clear, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0]  port;
        logic [31:0]  ip;
        logic [47:0]  mac;
        logic [135:0] str;
        logic [4:0]   len;
        logic         clr;
    } commit_t;

    logic [31:0] rq[$];
    string       rn[$];
    commit_t     cq[$];

    localparam logic [135:0] STR_PURDUE = {32'h70757264, 32'h75652E65, 32'h64750000, 32'h0, 8'h0};

    sniffer_cfg_ctrl dut (
        .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_write(cfg_write), .cfg_wdata(cfg_wdata),
        .cfg_read(cfg_read), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
        .sop(sop), .eop(eop), .valid(valid), .ready(ready),
        .port_hits(port_hits), .ip_hits(ip_hits), .mac_hits(mac_hits), .url_hits(url_hits),
        .flagged_port(flagged_port), .flagged_ip(flagged_ip), .flagged_mac(flagged_mac),
        .flagged_string(flagged_string), .strlen(strlen),
        .update_done(update_done), .clear(clear), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_commit(input logic [15:0] p, input logic [31:0] ip,
                                         input logic [47:0] m, input logic [135:0] s,
                                         input logic [4:0] l, input logic c);
        commit_t e;
        e.port = p; e.ip = ip; e.mac = m; e.str = s; e.len = l; e.clr = c;
        cq.push_back(e);
    endfunction

    // monitor
    always @(negedge clk) begin
        if (cfg_rvalid) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid: got rdata %0h expected no read", cfg_rdata);
            end else begin
                chk(rn.pop_front(), 136'(cfg_rdata), 136'(rq.pop_front()));
            end
        end
        if (update_done) begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_update_done: got 1 expected 0");
            end else begin
                commit_t e;
                e = cq.pop_front();
                chk("commit_port",   136'(flagged_port), 136'(e.port));
                chk("commit_ip",     136'(flagged_ip),   136'(e.ip));
                chk("commit_mac",    136'(flagged_mac),  136'(e.mac));
                chk("commit_string", flagged_string,     e.str);
                chk("commit_strlen", 136'(strlen),       136'(e.len));
                chk("commit_clear",  136'(clear),        136'(e.clr));
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_addr = a; cfg_wdata = d; cfg_write = 1'b1;
        @(negedge clk);
        cfg_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        cfg_addr = a; cfg_read = 1'b1;
        rq.push_back(exp); rn.push_back(name);
        @(negedge clk);
        cfg_read = 1'b0;
    endtask

    task automatic beat(input logic s, input logic e);
        @(negedge clk);
        valid = 1'b1; ready = 1'b1; sop = s; eop = e;
        @(negedge clk);
        valid = 1'b0; ready = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_addr = '0; cfg_write = 1'b0; cfg_wdata = '0; cfg_read = 1'b0;
        sop = 1'b0; eop = 1'b0; valid = 1'b0; ready = 1'b0;
        port_hits = '0; ip_hits = '0; mac_hits = '0; url_hits = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_port",   136'(flagged_port), 136'(0));
        chk("rst_ip",     136'(flagged_ip),   136'(0));
        chk("rst_mac",    136'(flagged_mac),  136'(0));
        chk("rst_string", flagged_string,     136'(0));
        chk("rst_strlen", 136'(strlen),       136'(0));
        chk("rst_pulses", 136'({update_done, clear, busy, cfg_rvalid}), 136'(0));
        chk("rst_rdata",  136'(cfg_rdata),    136'(0));
        rst = 1'b0;
        rd(5'h00, 32'h0, "rst_ctrl_read");

        // idle commit
        wr(5'h01, 32'h0000_0050);
        wr(5'h02, 32'h80D2_07C8);
        wr(5'h03, 32'h25EB_1080);
        wr(5'h04, 32'h0000_6412);
        wr(5'h08, 32'h7075_7264);
        wr(5'h09, 32'h7565_2E65);
        wr(5'h0A, 32'h6475_0000);
        wr(5'h05, 32'd10);
        rd(5'h01, 32'h50, "shadow_port_read");
        rd(5'h09, 32'h7565_2E65, "shadow_str1_read");
        rd(5'h04, 32'h6412, "shadow_mac_hi_read");
        chk("active_before_commit", 136'(flagged_port), 136'(0));
        push_commit(16'h0050, 32'h80D2_07C8, 48'h6412_25EB_1080, STR_PURDUE, 5'd10, 1'b0);
        wr(5'h00, 32'h1);
        chk("idle_commit_busy",  136'(busy), 136'(1));
        chk("idle_commit_early", 136'(update_done), 136'(0));
        @(negedge clk);
        chk("idle_commit_pulse", 136'(update_done), 136'(1));
        @(negedge clk);
        chk("idle_commit_pulse_end", 136'({update_done, busy}), 136'(0));

        // mid-packet commit waits for eop
        wr(5'h01, 32'h0000_1F90);
        beat(1'b1, 1'b0);
        push_commit(16'h1F90, 32'h0A00_0001, 48'h6412_25EB_1080, STR_PURDUE, 5'd10, 1'b1);
        wr(5'h00, 32'h3);
        rd(5'h00, 32'h3, "wait_ctrl_read");
        wr(5'h02, 32'h0A00_0001);
        for (int i = 0; i < 20; i++) begin
            beat(1'b0, 1'b0);
            if (i % 5 == 4) begin
                chk("wait_busy", 136'(busy), 136'(1));
                chk("wait_port_held", 136'(flagged_port), 136'(16'h0050));
                chk("wait_ip_held", 136'(flagged_ip), 136'(32'h80D2_07C8));
            end
        end
        beat(1'b0, 1'b1);
        chk("eop_apply_busy", 136'({busy, update_done}), 136'(2'b10));
        @(negedge clk);
        chk("eop_commit_pulse", 136'({update_done, clear, busy}), 136'(3'b110));
        rd(5'h00, 32'h0, "after_eop_ctrl_read");

        // commit coincident with eop beat goes straight to APPLY
        beat(1'b1, 1'b0);
        push_commit(16'h1F90, 32'h0A00_0001, 48'h6412_25EB_1080, STR_PURDUE, 5'd10, 1'b0);
        @(negedge clk);
        cfg_addr = 5'h00; cfg_wdata = 32'h1; cfg_write = 1'b1;
        valid = 1'b1; ready = 1'b1; eop = 1'b1;
        @(negedge clk);
        cfg_write = 1'b0; valid = 1'b0; ready = 1'b0; eop = 1'b0;
        chk("coincide_busy", 136'({busy, update_done}), 136'(2'b10));
        @(negedge clk);
        chk("coincide_pulse", 136'(update_done), 136'(1));
        beat(1'b1, 1'b1);
        rd(5'h00, 32'h0, "single_beat_in_packet");

        // clear_hits-only request acts as a commit
        push_commit(16'h1F90, 32'h0A00_0001, 48'h6412_25EB_1080, STR_PURDUE, 5'd10, 1'b1);
        wr(5'h00, 32'h2);
        repeat (2) @(negedge clk);

        // overrun
        beat(1'b1, 1'b0);
        push_commit(16'h1F90, 32'h0A00_0001, 48'h6412_25EB_1080, STR_PURDUE, 5'd10, 1'b0);
        wr(5'h00, 32'h1);
        wr(5'h00, 32'h1);
        rd(5'h00, 32'h7, "overrun_ctrl_read");
        beat(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rd(5'h00, 32'h4, "overrun_sticky");
        wr(5'h00, 32'h4);
        rd(5'h00, 32'h0, "overrun_cleared");

        // atomic hit reads
        url_hits = 64'h0000_0001_FFFF_FFFF;
        rd(5'h16, 32'hFFFF_FFFF, "url_lo");
        url_hits = 64'h0000_0002_0000_0000;
        rd(5'h17, 32'h0000_0001, "url_hi_held");
        port_hits = 64'h1234_5678_9ABC_DEF0;
        rd(5'h10, 32'h9ABC_DEF0, "port_lo");
        rd(5'h11, 32'h1234_5678, "port_hi");
        mac_hits = 64'hAAAA_0001_0000_0002;
        rd(5'h14, 32'h0000_0002, "mac_lo");
        rd(5'h17, 32'hAAAA_0001, "last_lo_wins");
        rd(5'h1F, 32'h0, "unmapped_1f");
        rd(5'h06, 32'h0, "unmapped_06");

        // register edge cases
        wr(5'h05, 32'd25);
        rd(5'h05, 32'd17, "strlen_saturate");
        wr(5'h0C, 32'hABCD_EF12);
        rd(5'h0C, 32'hAB00_0000, "str_word4");
        @(negedge clk);
        cfg_addr = 5'h01; cfg_wdata = 32'h1234; cfg_write = 1'b1; cfg_read = 1'b1;
        rq.push_back(32'h1F90); rn.push_back("read_before_write");
        @(negedge clk);
        cfg_write = 1'b0; cfg_read = 1'b0;
        rd(5'h01, 32'h1234, "read_after_write");

        // reset aborts a pending commit
        beat(1'b1, 1'b0);
        wr(5'h00, 32'h1);
        chk("pending_busy", 136'(busy), 136'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 136'(busy), 136'(0));
        chk("abort_port", 136'(flagged_port), 136'(0));
        beat(1'b0, 1'b1);
        repeat (4) @(negedge clk);

        while (rq.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_read %s: got nothing expected %0h", rn.pop_front(), rq.pop_front());
        end
        while (cq.size() != 0) begin
            commit_t e;
            e = cq.pop_front();
            checks++; errors++;
            $display("FAIL missing_update_done: got none expected port %0h", e.port);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sniffer_cfg_ctrl.md
Name: sniffer_cfg_ctrl

Overview:
- Host-side configuration controller for the ethernet sniffer.
- Holds shadow copies of the match targets (port, IP, MAC, URL string, string length) written over a simple register bus.
- Commits the shadow copies to the comparator-facing outputs only at a packet boundary, then pulses update_done (and optionally clear) to the sniffer.
- Exposes the sniffer's 64-bit hit counters to the host with atomic lo/hi reads.

Parameters:
- STR_BYTES, 17, bytes in flagged_string.
- HIT_W, 64, hit counter width; must be 64.
- ADDR_W, 5, cfg_addr width (word addresses).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_addr  in  ADDR_W  register word address
- cfg_write  in  1  write strobe
- cfg_wdata  in  32  write data
- cfg_read  in  1  read strobe
- cfg_rdata  out  32  read data
- cfg_rvalid  out  1  read data valid
- sop, eop, valid, ready  in  1 each  sniffer input stream framing
- port_hits, ip_hits, mac_hits, url_hits  in  HIT_W each  sniffer hit counters
- flagged_port  out  16  active target port
- flagged_ip  out  32  active target IP
- flagged_mac  out  48  active target MAC
- flagged_string  out  [0:STR_BYTES-1][7:0]  active target string; byte 0 is the first character
- strlen  out  5  active string length, 0..17
- update_done  out  1  one-cycle commit pulse
- clear  out  1  one-cycle hit-clear pulse
- busy  out  1  commit pending or applying

Behaviour:
- Reset: all outputs and all shadow/active registers are 0, state IDLE, in_packet 0, overrun 0. rst mid-commit aborts the commit; no update_done is issued.
- Register map (W = write, R = read, RW = both):
  - 0x00 CTRL:
    - W bit0 = commit, W bit1 = clear_hits request, W bit2 = clear overrun.
    - R bit0 = busy, R bit1 = in_packet, R bit2 = overrun.
  - 0x01 PORT[15:0], RW.
  - 0x02 IP, RW.
  - 0x03 MAC[31:0], RW.
  - 0x04 MAC[47:32] in bits [15:0], RW.
  - 0x05 STRLEN[4:0], RW. Writes >17 saturate to 17.
  - 0x08–0x0C STR word k: bytes 4k..4k+3, byte 4k in bits [31:24]. 0x0C uses only [31:24]; other bits read 0.
  - 0x10/0x11 port_hits lo/hi, 0x12/0x13 ip_hits, 0x14/0x15 mac_hits, 0x16/0x17 url_hits.
- Shadow register reads return shadow values, not active values. Unmapped reads return 0; unmapped writes are ignored.
- Reads: cfg_rdata/cfg_rvalid are registered, 1-cycle latency. Read and write to the same address in one cycle returns the pre-write value.
- Hit reads:
  - A lo read returns hits[31:0] and latches hits[63:32] into a single shared hold register.
  - A hi read returns the hold register. The last lo read wins.
- Packet tracking:
  - beat = valid & ready.
  - in_packet_next: set on beat & sop & !eop; cleared on beat & eop; otherwise held.
  - A single-beat packet (sop & eop on the same beat) leaves in_packet 0.
- State machine (IDLE, WAIT_GAP, APPLY):
  - IDLE: CTRL.commit write → APPLY if in_packet_next == 0, else WAIT_GAP. clear_hits is latched into clr_req.
  - WAIT_GAP: on beat & eop → APPLY.
  - APPLY: for one cycle, copy shadow → active on the edge leaving APPLY. update_done and clear (= clr_req) are registered high for exactly one cycle after that edge, coincident with the new flagged_* values. clr_req is then cleared and the state returns to IDLE.
  - Latency: commit written at edge E0 while idle → update_done high in the cycle after E1.
- Shadow writes while busy are accepted; APPLY uses the shadow contents at the APPLY cycle.
- A commit write while busy is ignored and sets sticky overrun. overrun clears only via CTRL bit2 or rst.
- A clear_hits-only write (bit1 set, bit0 clear) while IDLE behaves as a commit.
- busy = (state != IDLE).

Decomposition:
- Package sniffer_cfg_pkg holds:
  - register address localparams;
  - the state enum (IDLE, WAIT_GAP, APPLY);
  - STR_BYTES and the maximum STRLEN;
  - the CTRL bit indices.
- Sub-module pkt_boundary_tracker: sop/eop/valid/ready in; in_packet and in_packet_next out.

Test Plan:
- Reset: assert rst 2 cycles → all outputs 0, CTRL read returns 0x0.
- Idle commit: write PORT=0x0050, IP=0x80D207C8, MAC=0x641225EB1080, STR words "purd","ue.e","du\0\0", STRLEN=10, then CTRL=0x1 at E0 → cycle after E1: flagged_port=0x0050, flagged_ip=0x80D207C8, flagged_mac=0x641225EB1080, flagged_string starts "purdue.edu", strlen=10, update_done=1 for exactly 1 cycle, clear=0.
- Mid-packet commit: sop beat, then CTRL=0x3 → flagged_* unchanged and busy=1 for 20 beats. eop beat → next cycle APPLY; following cycle update_done=1 and clear=1; busy drops.
- Boundary coincidence: commit write on the same cycle as an eop beat → goes straight to APPLY, no WAIT_GAP. Single sop&eop beat during IDLE leaves in_packet 0.
- Overrun: second commit while in WAIT_GAP → one update_done only, CTRL read bit2=1. Write CTRL=0x4 → bit2 reads 0.
- Atomic hits: url_hits=0x0000_0001_FFFF_FFFF, read 0x16 → 0xFFFFFFFF. Change url_hits to 0x0000_0002_0000_0000, read 0x17 → 0x00000001. Unmapped read 0x1F → 0. STRLEN write of 25 → reads back 17.
